// File: rtl/consmax_share_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// consmax_share_ctrl : round-robin time-sharing and LUT sequencing for one consmax datapath
// Rev 1.0
// ----------------------------------------------------------------------------
module consmax_share_ctrl #(
    parameter  int HNUM      = 8,
    parameter  int IDATA_BIT = 8,
    parameter  int LUT_ADDR  = 4,
    parameter  int LUT_DATA  = 16,
    parameter  int SM_LAT    = 4,
    localparam int OW        = (HNUM > 1) ? $clog2(HNUM) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [HNUM-1:0]           req_valid,
    input  logic [HNUM*IDATA_BIT-1:0] req_data,
    input  logic [HNUM-1:0]           req_last,
    output logic [HNUM-1:0]           req_ready,
    input  logic                      lut_cfg_valid,
    input  logic [LUT_ADDR-1:0]       lut_cfg_addr,
    input  logic [LUT_DATA-1:0]       lut_cfg_data,
    input  logic                      lut_cfg_last,
    output logic                      lut_cfg_ready,
    output logic [IDATA_BIT-1:0]      sm_idata,
    output logic                      sm_idata_valid,
    output logic [LUT_ADDR-1:0]       sm_lut_waddr,
    output logic                      sm_lut_wen,
    output logic [LUT_DATA-1:0]       sm_lut_wdata,
    input  logic [IDATA_BIT-1:0]      sm_odata,
    input  logic                      sm_odata_valid,
    output logic [IDATA_BIT-1:0]      rsp_data,
    output logic [HNUM-1:0]           rsp_valid,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    output logic                      tag_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_LUT    = 2'd2
    } state_t;

    state_t              r_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_rr_ptr;
    logic                r_tag_v  [SM_LAT];
    logic [OW-1:0]       r_tag_id [SM_LAT];

    logic [OW-1:0]       w_grant;
    logic                w_found;
    logic                w_own_valid;
    logic                w_own_last;
    logic [IDATA_BIT-1:0] w_own_data;
    logic                w_tag_any;
    logic                w_drained;
    logic                w_beat;
    logic                w_lut_beat;
    logic [HNUM-1:0]     w_tail_oh;

    // Circular search for the first requester starting at the round-robin pointer
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        for (int i = 0; i < HNUM; i++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + i) % HNUM]) begin
                w_found = 1'b1;
                w_grant = OW'((int'(r_rr_ptr) + i) % HNUM);
            end
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        req_ready   = '0;
        w_tail_oh   = '0;
        for (int h = 0; h < HNUM; h++) begin
            if (r_owner == OW'(h)) begin
                w_own_valid  = req_valid[h];
                w_own_last   = req_last[h];
                w_own_data   = req_data[h*IDATA_BIT +: IDATA_BIT];
                req_ready[h] = (r_state == ST_STREAM);
            end
            w_tail_oh[h] = (r_tag_id[SM_LAT-1] == OW'(h));
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < SM_LAT; i++) begin
            w_tag_any = w_tag_any | r_tag_v[i];
        end
    end

    // A byte issued last cycle is still in flight even though its tag has not landed yet
    assign w_drained     = !w_tag_any && !sm_idata_valid;
    assign w_beat        = (r_state == ST_STREAM) && w_own_valid;
    assign w_lut_beat    = (r_state == ST_LUT) && lut_cfg_valid;
    assign lut_cfg_ready = (r_state == ST_LUT);
    assign busy          = (r_state != ST_IDLE) || w_tag_any;
    assign owner         = r_owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_owner        <= '0;
            r_rr_ptr       <= '0;
            sm_idata       <= '0;
            sm_idata_valid <= 1'b0;
            sm_lut_wen     <= 1'b0;
            sm_lut_waddr   <= '0;
            sm_lut_wdata   <= '0;
        end else begin
            sm_idata_valid <= w_beat;
            if (w_beat) begin
                sm_idata <= w_own_data;
            end
            sm_lut_wen <= w_lut_beat;
            if (w_lut_beat) begin
                sm_lut_waddr <= lut_cfg_addr;
                sm_lut_wdata <= lut_cfg_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (lut_cfg_valid) begin
                        if (w_drained) begin
                            r_state <= ST_LUT;
                        end
                    end else if (w_found) begin
                        r_owner <= w_grant;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_beat && w_own_last) begin
                        r_rr_ptr <= (r_owner == OW'(HNUM-1)) ? '0 : r_owner + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_LUT: begin
                    if (w_lut_beat && lut_cfg_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SM_LAT; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= sm_idata_valid;
            r_tag_id[0] <= r_owner;
            for (int i = 1; i < SM_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Any disagreement between the tag tail and the datapath output is a lost or orphan byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_data  <= '0;
            rsp_valid <= '0;
            tag_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (sm_odata_valid) begin
                rsp_data <= sm_odata;
                if (r_tag_v[SM_LAT-1]) begin
                    rsp_valid <= w_tail_oh;
                end
            end
            if (sm_odata_valid != r_tag_v[SM_LAT-1]) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_consmax_share_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_consmax_share_ctrl : scoreboard bench with a fixed-latency softmax model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_consmax_share_ctrl;
    localparam int HNUM = 8;
    localparam int IB   = 8;
    localparam int LA   = 4;
    localparam int LD   = 16;
    localparam int LAT  = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            tb_v [HNUM];
    logic            tb_l [HNUM];
    logic [IB-1:0]   tb_d [HNUM];
    logic [HNUM-1:0]    req_valid, req_last, req_ready, rsp_valid;
    logic [HNUM*IB-1:0] req_data;
    logic            lut_cfg_valid, lut_cfg_last, lut_cfg_ready;
    logic [LA-1:0]   lut_cfg_addr, sm_lut_waddr;
    logic [LD-1:0]   lut_cfg_data, sm_lut_wdata;
    logic [IB-1:0]   sm_idata, sm_odata, rsp_data;
    logic            sm_idata_valid, sm_lut_wen, sm_odata_valid;
    logic [2:0]      owner;
    logic            busy, tag_err, inject;

    always_comb begin
        for (int h = 0; h < HNUM; h++) begin
            req_valid[h]          = tb_v[h];
            req_last[h]           = tb_l[h];
            req_data[h*IB +: IB]  = tb_d[h];
        end
    end

    consmax_share_ctrl #(.HNUM(HNUM), .IDATA_BIT(IB), .LUT_ADDR(LA), .LUT_DATA(LD), .SM_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .lut_cfg_valid(lut_cfg_valid), .lut_cfg_addr(lut_cfg_addr), .lut_cfg_data(lut_cfg_data),
        .lut_cfg_last(lut_cfg_last), .lut_cfg_ready(lut_cfg_ready),
        .sm_idata(sm_idata), .sm_idata_valid(sm_idata_valid),
        .sm_lut_waddr(sm_lut_waddr), .sm_lut_wen(sm_lut_wen), .sm_lut_wdata(sm_lut_wdata),
        .sm_odata(sm_odata), .sm_odata_valid(sm_odata_valid),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .owner(owner), .busy(busy), .tag_err(tag_err)
    );

    function automatic logic [7:0] f(input logic [7:0] x);
        return x * 8'd3 + 8'h11;
    endfunction

    // Softmax stand-in: fixed LAT-cycle pipeline applying f()
    logic        m_v [LAT];
    logic [7:0]  m_d [LAT];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                m_v[i] <= 1'b0;
                m_d[i] <= '0;
            end
        end else begin
            m_v[0] <= sm_idata_valid;
            m_d[0] <= f(sm_idata);
            for (int i = 1; i < LAT; i++) begin
                m_v[i] <= m_v[i-1];
                m_d[i] <= m_d[i-1];
            end
        end
    end
    assign sm_odata_valid = m_v[LAT-1] | inject;
    assign sm_odata       = m_d[LAT-1];

    logic [59:0] all_out;
    assign all_out = {req_ready, lut_cfg_ready, sm_idata_valid, sm_lut_wen, rsp_valid, tag_err,
                      busy, owner, sm_idata, sm_lut_waddr, sm_lut_wdata, rsp_data};

    typedef struct { int head; logic [7:0] data; int cyc; } exp_t;
    typedef struct { logic [3:0] a; logic [15:0] d; } lexp_t;
    exp_t  sb_q [$];
    lexp_t lut_q [$];
    int    grant_q [$];
    exp_t  e;
    lexp_t le;
    int checks = 0, errors = 0, cyc = 0;
    int last_rsp_cyc, lut_wen_cnt, lut_first_acc, lut_last_acc;
    int first_acc [HNUM];
    int last_acc  [HNUM];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected responses and LUT writes as the DUT presents them
    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_head", 64'(rsp_valid), 64'(1 << e.head));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_latency", 64'(cyc - e.cyc), 64'(LAT + 2));
                    last_rsp_cyc = cyc;
                end
            end
            if (sm_lut_wen) begin
                lut_wen_cnt++;
                if (lut_q.size() == 0) begin
                    chk("lut_unexpected", 64'(sm_lut_wen), 64'd0);
                end else begin
                    le = lut_q.pop_front();
                    chk("lut_addr", 64'(sm_lut_waddr), 64'(le.a));
                    chk("lut_data", 64'(sm_lut_wdata), 64'(le.d));
                end
            end
            if (lut_cfg_ready) chk("ready_in_load", 64'(req_ready), 64'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int h, input int n, input logic [7:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            int t;
            tb_v[h] = 1'b1;
            tb_d[h] = base + 8'(i);
            tb_l[h] = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_ready[h] && t < 300);
            if (!req_ready[h]) begin
                chk("accept_timeout", 64'(req_ready[h]), 64'd1);
                tb_v[h] = 1'b0;
                tb_l[h] = 1'b0;
                return;
            end
            if (i == 0) begin
                first_acc[h] = cyc;
                grant_q.push_back(h);
            end
            if (i == n - 1) last_acc[h] = cyc;
            sb_q.push_back('{h, f(base + 8'(i)), cyc});
            @(posedge clk);
            #1;
            if (gap > 0 && i < n - 1) begin
                tb_v[h] = 1'b0;
                wait_cyc(gap);
            end
        end
        tb_v[h] = 1'b0;
        tb_l[h] = 1'b0;
    endtask

    task automatic lut_load(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            lut_cfg_valid = 1'b1;
            lut_cfg_addr  = 4'(i);
            lut_cfg_data  = 16'h3C00 + 16'(i);
            lut_cfg_last  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!lut_cfg_ready && t < 300);
            if (!lut_cfg_ready) begin
                chk("lut_timeout", 64'(lut_cfg_ready), 64'd1);
                lut_cfg_valid = 1'b0;
                lut_cfg_last  = 1'b0;
                return;
            end
            if (i == 0) lut_first_acc = cyc;
            lut_last_acc = cyc;
            lut_q.push_back('{4'(i), 16'h3C00 + 16'(i)});
            @(posedge clk);
            #1;
        end
        lut_cfg_valid = 1'b0;
        lut_cfg_last  = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        for (int h = 0; h < HNUM; h++) begin
            tb_v[h] = 1'b0;
            tb_l[h] = 1'b0;
        end
        lut_cfg_valid = 1'b0;
        lut_cfg_last  = 1'b0;
        inject        = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        lut_q.delete();
        grant_q.delete();
        rstn = 1'b1;
        wait_cyc(1);
    endtask

    initial begin
        int t;
        for (int h = 0; h < HNUM; h++) begin
            tb_v[h] = 1'b0;
            tb_l[h] = 1'b0;
            tb_d[h] = '0;
        end
        lut_cfg_valid = 1'b0;
        lut_cfg_last  = 1'b0;
        lut_cfg_addr  = '0;
        lut_cfg_data  = '0;
        inject        = 1'b0;
        lut_wen_cnt   = 0;
        last_rsp_cyc  = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(all_out), 64'd0);
        rstn = 1'b1;
        wait_cyc(1);

        // Single head, then round-robin resumes after head 2
        send_pkt(2, 3, 8'h10, 0);
        wait_cyc(12);
        fork
            send_pkt(1, 2, 8'h30, 0);
            send_pkt(4, 2, 8'h40, 0);
        join
        wait_cyc(12);
        chk("rr_after_head2_a", 64'(grant_q[1]), 64'd4);
        chk("rr_after_head2_b", 64'(grant_q[2]), 64'd1);
        chk("idle_gap_4_1", 64'(first_acc[1]), 64'(last_acc[4] + 2));

        // Three simultaneous requesters from a fresh pointer
        reset_dut();
        fork
            send_pkt(0, 2, 8'h50, 0);
            send_pkt(3, 2, 8'h60, 0);
            send_pkt(5, 2, 8'h70, 0);
        join
        wait_cyc(12);
        chk("order_0", 64'(grant_q[0]), 64'd0);
        chk("order_1", 64'(grant_q[1]), 64'd3);
        chk("order_2", 64'(grant_q[2]), 64'd5);
        chk("idle_gap_0_3", 64'(first_acc[3]), 64'(last_acc[0] + 2));
        chk("idle_gap_3_5", 64'(first_acc[5]), 64'(last_acc[3] + 2));

        // LUT load arriving while head 1 streams with gaps
        lut_wen_cnt = 0;
        fork
            send_pkt(1, 4, 8'h80, 1);
            begin
                wait_cyc(2);
                lut_load(16);
            end
        join
        wait_cyc(4);
        chk("lut_wen_count", 64'(lut_wen_cnt), 64'd16);
        chk("lut_after_drain", 64'(lut_first_acc > last_rsp_cyc), 64'd1);
        chk("lut_q_empty", 64'(lut_q.size()), 64'd0);

        // LUT and head 4 together from idle: LUT wins
        reset_dut();
        fork
            lut_load(4);
            send_pkt(4, 1, 8'h90, 0);
        join
        wait_cyc(12);
        chk("head4_after_lut", 64'(first_acc[4]), 64'(lut_last_acc + 2));

        // Orphan output with an empty tag pipe
        inject = 1'b1;
        wait_cyc(1);
        inject = 1'b0;
        @(negedge clk);
        chk("tag_err_set", 64'(tag_err), 64'd1);
        chk("orphan_rsp_valid", 64'(rsp_valid), 64'd0);
        send_pkt(6, 2, 8'hB0, 0);
        wait_cyc(12);
        chk("tag_err_sticky", 64'(tag_err), 64'd1);
        reset_dut();
        @(negedge clk);
        chk("tag_err_cleared", 64'(tag_err), 64'd0);

        // Reset dropped mid-packet, then head 0 again
        wait_cyc(1);
        tb_v[0] = 1'b1;
        tb_d[0] = 8'hC0;
        tb_l[0] = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[0] && t < 300);
        if (!req_ready[0]) chk("abort_accept_timeout", 64'(req_ready[0]), 64'd1);
        wait_cyc(1);
        tb_d[0] = 8'hC1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_outputs", 64'(all_out), 64'd0);
        reset_dut();
        send_pkt(0, 2, 8'hA0, 0);
        wait_cyc(12);
        chk("post_abort_grant", 64'(grant_q[0]), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/consmax_share_ctrl.md
Name: consmax_share_ctrl

Overview:
- Time-shares one softmax (consmax) datapath instance among HNUM head requesters.
- Also sequences the datapath's LUT programming.
- Arbitrates packet-granular, round-robin access to the softmax input.
- Tracks ownership of in-flight data through the fixed-latency softmax pipeline, routes each output byte back to its originating head, and only reprograms the LUT when the pipeline is drained.

Parameters:
HNUM, 8, number of requesting heads
IDATA_BIT, 8, softmax input/output byte width
LUT_ADDR, 4, LUT address width
LUT_DATA, 16, LUT entry width
SM_LAT, 4, fixed softmax latency in cycles from sm_idata_valid to sm_odata_valid (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  HNUM  per-head input byte valid
req_data  in  HNUM*IDATA_BIT  per-head input bytes; head h occupies [h*8 +: 8]
req_last  in  HNUM  last byte of head's packet
req_ready  out  HNUM  per-head accept
lut_cfg_valid  in  1  LUT write beat valid
lut_cfg_addr  in  LUT_ADDR  LUT write address
lut_cfg_data  in  LUT_DATA  LUT write data
lut_cfg_last  in  1  final LUT beat
lut_cfg_ready  out  1  LUT beat accept
sm_idata  out  IDATA_BIT  to softmax idata
sm_idata_valid  out  1  to softmax idata_valid
sm_lut_waddr  out  LUT_ADDR  to softmax lut_waddr
sm_lut_wen  out  1  to softmax lut_wen
sm_lut_wdata  out  LUT_DATA  to softmax lut_wdata
sm_odata  in  IDATA_BIT  from softmax odata
sm_odata_valid  in  1  from softmax odata_valid
rsp_data  out  IDATA_BIT  registered softmax output byte
rsp_valid  out  HNUM  one-hot destination head for rsp_data
owner  out  clog2(HNUM)  current/last granted head
busy  out  1  state != IDLE or any in-flight tag
tag_err  out  1  sticky: sm_odata_valid with no valid tag at pipeline tail

Behaviour:
- Reset (async, rstn=0): state=IDLE, rr_ptr=0, owner=0, tag pipe cleared. Outputs req_ready, lut_cfg_ready, sm_idata_valid, sm_lut_wen, rsp_valid, tag_err = 0. All data outputs = 0. Asserting reset mid-packet or mid-load aborts it with no completion.
- States: IDLE, STREAM, LUT_LOAD.
- IDLE:
  - If lut_cfg_valid=1 and the tag pipe is empty: go to LUT_LOAD. LUT has priority over requests.
  - Else if lut_cfg_valid=1 and the pipe is non-empty: stay in IDLE, grant nothing; requests are held off until drain.
  - Else if any req_valid: owner <= first h with req_valid[h], searching circularly from rr_ptr; go to STREAM next cycle.
  - Arbitration costs one idle cycle per packet.
- STREAM:
  - req_ready = one-hot(owner); all other bits 0.
  - On req_valid[owner]&req_ready[owner]: next cycle sm_idata=req_data[owner] and sm_idata_valid=1; otherwise sm_idata_valid=0.
  - On an accepted beat with req_last[owner]=1: rr_ptr <= (owner+1) mod HNUM, go to IDLE.
  - Gaps in req_valid are allowed; the grant holds until last.
  - lut_cfg_valid is ignored during STREAM.
- LUT_LOAD:
  - lut_cfg_ready=1.
  - Each accepted beat registers sm_lut_wen=1, sm_lut_waddr, sm_lut_wdata one cycle later.
  - Accepted beat with lut_cfg_last=1: go to IDLE.
  - req_ready=0 throughout.
- Tag pipe:
  - SM_LAT-deep shift of {valid, id}. Entry 0 loads {sm_idata_valid, owner-at-issue} each cycle.
  - On sm_odata_valid: rsp_data <= sm_odata and rsp_valid <= one-hot(tail.id) next cycle.
  - If tail.valid=0: rsp_valid stays 0 and tag_err is set (sticky until reset).
  - Tail valid without sm_odata_valid: byte dropped and tag_err set.
- Total latency from req accept to rsp_valid = SM_LAT+2 cycles.
- The pipe is empty when all tag valids are 0; busy reflects this.
- Single-byte packet (valid & last on the same beat) is legal.
- HNUM=1 degenerates to a pass-through with one arbitration cycle.

Test Plan:
- Reset, then head 2 sends 3 bytes 0x10, 0x11, 0x12 (last on 0x12) with a softmax model of latency 4 → rsp_valid=0x04 for 3 consecutive cycles starting 6 cycles after the first accept; rsp_data matches the model; rr_ptr=3.
- Heads 0, 3, 5 all request 2-byte packets simultaneously → grant order 0, 3, 5; one IDLE cycle between packets; responses are tagged to the correct heads.
- LUT load of 16 beats (addr 0..15, data 0x3C00+addr) arrives while head 1 streams → load waits for head 1's last and for the tag pipe to empty; sm_lut_wen fires 16 times with matching addr/data; req_ready stays 0 during the load.
- lut_cfg_valid and req_valid[4] asserted together in IDLE with an empty pipe → LUT_LOAD first; head 4 granted after lut_cfg_last.
- Inject sm_odata_valid while the tag pipe is empty → tag_err=1 and rsp_valid=0; tag_err persists until rstn=0.
- Drop rstn mid-packet → all outputs are 0 immediately; the next packet from head 0 is granted normally after release.
